// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product engine.
//   state_e       : control FSM states
//   Def*          : default widths used by the top-level parameters
package dotprod_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefCntW  = 32;
  localparam int unsigned DefAccW  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/dotprod_if.sv
// Single-port SRAM read bus (1-cycle read latency).
//   master : engine side  - drives address0/ce0/we0, receives q0
//   slave  : memory side  - receives address0/ce0/we0, drives q0
interface dotprod_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] address0;
  logic              ce0;
  logic              we0;
  logic [DATA_W-1:0] q0;

  modport master (output address0, output ce0, output we0, input q0);
  modport slave  (input address0, input ce0, input we0, output q0);
endinterface

// File: rtl/dotprod_mac_stage.sv
// Multiply-accumulate back end of the dot-product engine.
//   issue   : a read was issued this cycle; q data arrives next cycle
//   a_q/b_q : SRAM read data
//   clear   : reload accumulator with seed and clear the overflow flag
//   busy    : read data still in flight (one cycle after the last issue)
//   acc/ovf : running accumulator and sticky overflow flag
module dotprod_mac_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [ACC_W-1:0]  seed,
  input  logic              mode_signed,
  input  logic              issue,
  input  logic [DATA_W-1:0] a_q,
  input  logic [DATA_W-1:0] b_q,
  output logic              busy,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  localparam int unsigned ProdW = 2 * DATA_W;

  logic             q_valid_q, prod_valid_q;
  logic [ProdW-1:0] a_ext, b_ext, prod_d, prod_q;
  logic [ACC_W-1:0] prod_ext, acc_q, sum;
  logic [ACC_W:0]   sum_wide;
  logic             prod_sx, ovf_now, ovf_q;

  // Extending operands to the full product width makes one unsigned multiply
  // produce the correct low 2*DATA_W bits in both signed and unsigned mode.
  always_comb begin
    a_ext  = {{DATA_W{mode_signed & a_q[DATA_W-1]}}, a_q};
    b_ext  = {{DATA_W{mode_signed & b_q[DATA_W-1]}}, b_q};
    prod_d = a_ext * b_ext;
  end

  assign prod_sx = mode_signed & prod_q[ProdW-1];

  if (ACC_W > ProdW) begin : g_ext
    assign prod_ext = {{(ACC_W - ProdW){prod_sx}}, prod_q};
  end else begin : g_noext
    assign prod_ext = prod_q;
  end

  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
    sum      = sum_wide[ACC_W-1:0];
    if (mode_signed) begin
      ovf_now = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_now = sum_wide[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid_q    <= 1'b0;
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      q_valid_q    <= issue;
      prod_valid_q <= q_valid_q;
      if (q_valid_q) begin
        prod_q <= prod_d;
      end
      if (clear) begin
        acc_q <= seed;
        ovf_q <= 1'b0;
      end else if (prod_valid_q) begin
        acc_q <= sum;
        ovf_q <= ovf_q | ovf_now;
      end
    end
  end

  assign busy = q_valid_q;
  assign acc  = acc_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/dotprod_engine.sv
// Pipelined dot-product accelerator: sum(a[a_base+i] * b[b_base+i]), i = 0..n-1.
//   ap_clk/ap_rst_n           : clock, asynchronous active-low reset
//   ap_start/idle/done/ready  : block-level handshake
//   n/a_base/b_base           : element count and base addresses, latched at start
//   mode_signed/acc_keep      : operand signedness and accumulate chaining, latched at start
//   a_mem/b_mem               : SRAM read ports
//   ap_return/ap_ovf          : result (held until next completion), sticky overflow
module dotprod_engine
  import dotprod_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  input  logic [CNT_W-1:0]  n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic              mode_signed,
  input  logic              acc_keep,
  dotprod_if.master         a_mem,
  dotprod_if.master         b_mem,
  output logic [ACC_W-1:0]  ap_return,
  output logic              ap_ovf
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, n_q, last_idx;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic              mode_q;
  logic [ACC_W-1:0]  ret_q, seed, mac_acc;
  logic              start_fire, issue, mac_busy, mac_ovf;

  assign start_fire = (state_q == StIdle) && ap_start;
  assign last_idx   = n_q - CNT_W'(1);
  assign seed       = acc_keep ? ret_q : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ap_start) state_d = (n == '0) ? StDone : StRun;
      StRun:   if (cnt_q == last_idx) state_d = StDrain;
      StDrain: if (!mac_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue          = (state_q == StRun);
    ap_idle        = (state_q == StIdle);
    ap_done        = (state_q == StDone);
    ap_ready       = (state_q == StDone);
    a_mem.ce0      = issue;
    b_mem.ce0      = issue;
    a_mem.we0      = 1'b0;
    b_mem.we0      = 1'b0;
    a_mem.address0 = issue ? a_base_q + ADDR_W'(cnt_q) : '0;
    b_mem.address0 = issue ? b_base_q + ADDR_W'(cnt_q) : '0;
    // The final accumulate lands on the edge that enters DONE, so expose it live.
    ap_return      = (state_q == StDone) ? mac_acc : ret_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q    <= '0;
      n_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      mode_q   <= 1'b0;
      ret_q    <= '0;
    end else begin
      if (start_fire) begin
        cnt_q    <= '0;
        n_q      <= n;
        a_base_q <= a_base;
        b_base_q <= b_base;
        mode_q   <= mode_signed;
      end else if (issue) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == StDone) begin
        ret_q <= mac_acc;
      end
    end
  end

  dotprod_mac_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk         (ap_clk),
    .rst_n       (ap_rst_n),
    .clear       (start_fire),
    .seed        (seed),
    .mode_signed (mode_q),
    .issue       (issue),
    .a_q         (a_mem.q0),
    .b_q         (b_mem.q0),
    .busy        (mac_busy),
    .acc         (mac_acc),
    .ovf         (mac_ovf)
  );

  assign ap_ovf = mac_ovf;

endmodule

// File: tb/tb_dotprod_engine.sv
// Directed bench for dotprod_engine: a 32/32/32/64 instance for the main runs
// and an 8/8/8/16 instance for accumulator wrap and carry-out.
module tb_dotprod_engine;

  logic clk = 1'b0;
  logic ap_rst_n;
  always #5 clk = ~clk;

  // Main DUT
  logic        ap_start, ap_idle, ap_done, ap_ready, mode_signed, acc_keep, ap_ovf;
  logic [31:0] n, a_base, b_base;
  logic [63:0] ap_return;
  dotprod_if #(.DATA_W(32), .ADDR_W(32)) a_if ();
  dotprod_if #(.DATA_W(32), .ADDR_W(32)) b_if ();
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  dotprod_engine u_dut (
    .ap_clk      (clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .n           (n),
    .a_base      (a_base),
    .b_base      (b_base),
    .mode_signed (mode_signed),
    .acc_keep    (acc_keep),
    .a_mem       (a_if),
    .b_mem       (b_if),
    .ap_return   (ap_return),
    .ap_ovf      (ap_ovf)
  );

  always @(posedge clk) if (a_if.ce0) a_if.q0 <= mem_a[a_if.address0[3:0]];
  always @(posedge clk) if (b_if.ce0) b_if.q0 <= mem_b[b_if.address0[3:0]];

  // Small DUT with ACC_W == 2*DATA_W
  logic        s_start, s_idle, s_done, s_ready, s_ovf;
  logic [7:0]  s_n, s_a_base, s_b_base;
  logic [15:0] s_return;
  dotprod_if #(.DATA_W(8), .ADDR_W(8)) sa_if ();
  dotprod_if #(.DATA_W(8), .ADDR_W(8)) sb_if ();
  logic [7:0] mem_sa [4];
  logic [7:0] mem_sb [4];

  dotprod_engine #(
    .DATA_W (8),
    .ADDR_W (8),
    .CNT_W  (8),
    .ACC_W  (16)
  ) u_small (
    .ap_clk      (clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (s_start),
    .ap_idle     (s_idle),
    .ap_done     (s_done),
    .ap_ready    (s_ready),
    .n           (s_n),
    .a_base      (s_a_base),
    .b_base      (s_b_base),
    .mode_signed (1'b0),
    .acc_keep    (1'b0),
    .a_mem       (sa_if),
    .b_mem       (sb_if),
    .ap_return   (s_return),
    .ap_ovf      (s_ovf)
  );

  always @(posedge clk) if (sa_if.ce0) sa_if.q0 <= mem_sa[sa_if.address0[1:0]];
  always @(posedge clk) if (sb_if.ce0) sb_if.q0 <= mem_sb[sb_if.address0[1:0]];

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive config with ap_start=1 and return 1 time unit after the sampling edge E0.
  task automatic kick(input logic [31:0] nn, input logic [31:0] ab, input logic [31:0] bb,
                      input logic ms, input logic keep, input logic hold);
    @(negedge clk);
    n = nn; a_base = ab; b_base = bb; mode_signed = ms; acc_keep = keep; ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = hold;
  endtask

  // Called just after E0. edge_idx = k where ap_done is first seen in cycle E(k)..E(k+1);
  // ces counts cycles with both chip enables high before that.
  task automatic run_wait(input int unsigned limit, output int unsigned edge_idx,
                          output int unsigned ces, output bit ok);
    edge_idx = 0; ces = 0; ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (ap_done) begin
        ok = 1'b1;
      end else begin
        if (a_if.ce0 && b_if.ce0) ces++;
        edge_idx++;
      end
    end
  endtask

  int unsigned e, ces;
  bit          ok;

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; n = '0; a_base = '0; b_base = '0;
    mode_signed = 1'b0; acc_keep = 1'b0;
    s_start = 1'b0; s_n = '0; s_a_base = '0; s_b_base = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < 10; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[i] = 32'(10 - i);
    end
    mem_a[12] = 32'hFFFF_FFFD; mem_a[13] = 32'd4;
    mem_b[12] = 32'd5;         mem_b[13] = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      mem_sa[i] = 8'hFF;
      mem_sb[i] = 8'hFF;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_ready", 64'(ap_ready), 64'd0);
    check("rst_ce", 64'({a_if.ce0, b_if.ce0}), 64'd0);
    check("rst_addr", 64'(a_if.address0), 64'd0);
    check("rst_ret", ap_return, 64'd0);
    check("rst_ovf", 64'(ap_ovf), 64'd0);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: unsigned 1..10 . 10..1
    kick(32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("t1_busy", 64'(ap_idle), 64'd0);
    check("t1_ce_first", 64'({a_if.ce0, b_if.ce0}), 64'd3);
    check("t1_addr_first", 64'(a_if.address0), 64'd0);
    check("t1_we", 64'({a_if.we0, b_if.we0}), 64'd0);
    run_wait(40, e, ces, ok);
    check("t1_done_seen", 64'(ok), 64'd1);
    check("t1_done_edge", 64'(e), 64'd12);
    check("t1_ce_count", 64'(ces), 64'd10);
    check("t1_ready", 64'(ap_ready), 64'd1);
    check("t1_ret", ap_return, 64'd220);
    check("t1_ovf", 64'(ap_ovf), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(ap_done), 64'd0);
    check("t1_ret_held", ap_return, 64'd220);
    check("t1_idle_after", 64'(ap_idle), 64'd1);

    // 2: n == 0
    kick(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("t2_ce", 64'({a_if.ce0, b_if.ce0}), 64'd0);
    run_wait(10, e, ces, ok);
    check("t2_done_seen", 64'(ok), 64'd1);
    check("t2_done_edge", 64'(e), 64'd0);
    check("t2_ret", ap_return, 64'd0);

    // 3: signed {-3,4} . {5,-2} from base 12
    kick(32'd2, 32'd12, 32'd12, 1'b1, 1'b0, 1'b0);
    check("t3_addr_a", 64'(a_if.address0), 64'd12);
    check("t3_addr_b", 64'(b_if.address0), 64'd12);
    run_wait(20, e, ces, ok);
    check("t3_done_seen", 64'(ok), 64'd1);
    check("t3_done_edge", 64'(e), 64'd4);
    check("t3_ret", ap_return, 64'hFFFF_FFFF_FFFF_FFE9);
    check("t3_ovf", 64'(ap_ovf), 64'd0);

    // 4: run 1 with ap_start held, then chained run with acc_keep
    kick(32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    run_wait(40, e, ces, ok);
    check("t4a_done_edge", 64'(e), 64'd12);
    check("t4a_ret", ap_return, 64'd220);
    acc_keep = 1'b1;
    @(negedge clk);
    check("t4_gap_idle", 64'(ap_idle), 64'd1);
    @(posedge clk);
    #1;
    check("t4_restart", 64'(ap_idle), 64'd0);
    ap_start = 1'b0;
    run_wait(40, e, ces, ok);
    check("t4b_done_seen", 64'(ok), 64'd1);
    check("t4b_done_edge", 64'(e), 64'd12);
    check("t4b_ret", ap_return, 64'd440);
    acc_keep = 1'b0;
    @(negedge clk);

    // 5: 8-bit unsigned all-ones, 16-bit accumulator wraps with carry-out
    s_n = 8'd2; s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s_done) ok = 1'b1;
    end
    check("t5_done_seen", 64'(ok), 64'd1);
    check("t5_ret", 64'(s_return), 64'h0000_0000_0000_FC02);
    check("t5_ovf", 64'(s_ovf), 64'd1);

    // 6: reset at E5 of a run, then rerun
    kick(32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("t6_ce", 64'({a_if.ce0, b_if.ce0}), 64'd0);
    check("t6_idle", 64'(ap_idle), 64'd1);
    check("t6_ret", ap_return, 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ap_done) ok = 1'b1;
      if (i == 2) ap_rst_n = 1'b1;
    end
    check("t6_no_done", 64'(ok), 64'd0);
    kick(32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    run_wait(40, e, ces, ok);
    check("t6_done_edge", 64'(e), 64'd12);
    check("t6_ret_rerun", ap_return, 64'd220);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
